program_counter: RTL

//   Fetch-address generator feeding instruction_memory.read_adress. Holds the
//   PC, selects next PC among sequential / branch / jump / jr and stops fetch
//   at end of program. Decode fields (immediate_data, jumpAdd) come back from

---
 rtl/program_counter_if.sv | 27 ++
 rtl/program_counter.sv | 92 +++++++++
 2 files changed

// File: rtl/program_counter_if.sv
// Fetch-side bus of the program counter: decode/ALU controls in, fetch address and status out.
interface program_counter_if;
    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;
    logic        jr_sel;
    logic [15:0] immediate_data;
    logic [25:0] jumpAdd;
    logic [31:0] jr_target;
    logic [31:0] read_adress;
    logic [31:0] pc_plus1;
    logic        fetch_valid;
    logic        halted;
    logic [31:0] instr_count;

    // master is the program counter itself: it owns the fetch address toward instruction memory
    modport master (
        input  stall, branch, zero, jump, jr_sel, immediate_data, jumpAdd, jr_target,
        output read_adress, pc_plus1, fetch_valid, halted, instr_count
    );

    modport slave (
        output stall, branch, zero, jump, jr_sel, immediate_data, jumpAdd, jr_target,
        input  read_adress, pc_plus1, fetch_valid, halted, instr_count
    );
endinterface

// File: rtl/program_counter.sv
// Word-indexed fetch address generator: selects sequential/branch/jump/jr next PC,
// counts PC advances and freezes fetch once the next PC would fall outside instruction memory.
module program_counter #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int unsigned IMEM_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    program_counter_if.master bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH32 = 32'(IMEM_DEPTH);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic [31:0] branch_target;
    logic [31:0] next_pc;
    logic [31:0] count;
    logic        past_end;
    logic        advance;

    assign pc_plus1      = pc + 32'd1;
    assign branch_target = pc_plus1 + {{16{bus.immediate_data[15]}}, bus.immediate_data};

    always_comb begin
        next_pc = pc_plus1;
        if (bus.jr_sel) begin
            next_pc = bus.jr_target;
        end else if (bus.jump) begin
            next_pc = {pc_plus1[31:26], bus.jumpAdd};
        end else if (bus.branch && bus.zero) begin
            next_pc = branch_target;
        end
    end

    // Negative branch offsets wrap to huge unsigned values, so one compare catches both ends
    assign past_end = (next_pc >= DEPTH32);
    assign advance  = (state == RUN) && !bus.stall && !past_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (!bus.stall && past_end) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        bus.fetch_valid = 1'b0;
        bus.halted      = 1'b0;
        case (state)
            RUN:     bus.fetch_valid = 1'b1;
            HALT:    bus.halted      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            count <= 32'd0;
        end else if (advance) begin
            pc <= next_pc;
            if (count != 32'hFFFF_FFFF) begin
                count <= count + 32'd1;
            end
        end
    end

    assign bus.read_adress = pc;
    assign bus.pc_plus1    = pc_plus1;
    assign bus.instr_count = count;

endmodule
